// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg : shared AES-128 key-schedule constants, state enum and helpers  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  // RCON[i] holds rcon[i+1]; round index 0 has no rcon.
  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] xor_word(input logic [31:0] a, input logic [31:0] b);
    return a ^ b;
  endfunction

  function automatic logic [31:0] rcon_word(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) rc = RCON[idx - 4'd1];
    return {rc, 24'h000000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_sbox : combinational AES forward S-box (GF(2^8) inverse + affine)    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // x^254 = x^-1 (and maps 0 to 0): product of x^2, x^4, ... x^128.
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_inv_key_sched : AES-128 round keys emitted in reverse (10 down to 0) |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round
);

  state_t           state;
  state_t           state_nx;
  logic [KEY_W-1:0] k;
  logic [3:0]       r;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_src, rot, sub, t;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  rc_idx;
  logic        emit;

  assign {w0, w1, w2, w3} = k;
  assign emit = (state == EMIT);

  // Going backwards, the previous w3 is w3^w2, so both directions share one SubWord.
  assign sub_src = emit ? xor_word(w3, w2) : w3;
  assign rot     = rot_word(sub_src);
  assign rc_idx  = emit ? r : r + 4'd1;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot[8*i +: 8]),
      .out_byte (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ rcon_word(rc_idx);
  assign n0 = xor_word(w0, t);
  assign n1 = xor_word(w1, n0);
  assign n2 = xor_word(w2, n1);
  assign n3 = xor_word(w3, n2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = EXPAND;
      EXPAND:  if (r == 4'(NR - 1)) state_nx = EMIT;
      EMIT:    if (rk_ready && r == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      r        <= 4'd0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
    end else begin
      busy     <= (state_nx != IDLE);
      rk_valid <= (state_nx == EMIT);
      case (state)
        IDLE: begin
          if (start) begin
            k <= key_in;
            r <= 4'd0;
          end
        end
        EXPAND: begin
          k <= {n0, n1, n2, n3};
          r <= r + 4'd1;
        end
        EMIT: begin
          if (rk_ready && r != 4'd0) begin
            k <= {n0, xor_word(w1, w0), xor_word(w2, w1), xor_word(w3, w2)};
            r <= r - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rk_out   = k;
  assign rk_round = r;

endmodule
`default_nettype wire
